// File: rtl/dump_pkg.sv
// dump_pkg: shared definitions for the binary state-dump transmitter.
//   - dump_state_t : top-level sequencing states (bank/address walk)
//   - line_state_t : per-line serializer states (digits, terminator)
//   - ASCII constants and bank-select encodings
//   - digit_char() : maps one bit to its '0'/'1' character
// Optional feature macro: DUMP_CRLF_EN adds the LN_SEND_CR state so each line
// ends with CR LF instead of LF alone.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } dump_state_t;

  typedef enum logic [1:0] {
    LN_IDLE,
    LN_SEND_BIT,
`ifdef DUMP_CRLF_EN
    LN_SEND_CR,
`endif
    LN_SEND_NL
  } line_state_t;

  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_1  = 8'h31;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  localparam logic BANK_REG = 1'b0;
  localparam logic BANK_MEM = 1'b1;

  function automatic logic [7:0] digit_char(input logic bit_val);
    return bit_val ? CHAR_1 : CHAR_0;
  endfunction

endpackage

// File: rtl/dump_line_ser.sv
// dump_line_ser: turns one captured word into an ASCII line of '0'/'1'
// digits, MSB first, followed by the line terminator, over valid/ready.
// Ports:
//   clock, reset     clock, asynchronous active-low reset
//   load             capture word and begin a line (honoured only when idle)
//   word[WORD_W]     word to serialize
//   tx_ready         sink accepts tx_data on posedge when tx_valid && tx_ready
//   tx_data[8]       current ASCII byte (registered, held until accepted)
//   tx_valid         byte available
//   line_done        high in the cycle the final terminator byte is accepted
// Optional feature macro: DUMP_CRLF_EN emits CR before LF.
module dump_line_ser
  import dump_pkg::*;
#(
  parameter int WORD_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              line_done
);

  localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  line_state_t       state_reg;
  logic [WORD_W-1:0] shift_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WORD_W-1:0] shift_next;
  logic              accept;

  assign shift_next = shift_reg << 1;
  assign accept     = tx_valid && tx_ready;
  assign line_done  = accept && (state_reg == LN_SEND_NL);

  // tx_data always holds the byte for the current state, so it is stable
  // from the moment tx_valid rises until the handshake moves it on.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= LN_IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
    end else begin
      case (state_reg)
        LN_IDLE: begin
          if (load) begin
            shift_reg <= word;
            cnt_reg   <= CNT_LAST;
            tx_data   <= digit_char(word[WORD_W-1]);
            tx_valid  <= 1'b1;
            state_reg <= LN_SEND_BIT;
          end
        end
        LN_SEND_BIT: begin
          if (accept) begin
            if (cnt_reg == '0) begin
`ifdef DUMP_CRLF_EN
              tx_data   <= CHAR_CR;
              state_reg <= LN_SEND_CR;
`else
              tx_data   <= CHAR_LF;
              state_reg <= LN_SEND_NL;
`endif
            end else begin
              shift_reg <= shift_next;
              cnt_reg   <= cnt_reg - CNT_W'(1);
              tx_data   <= digit_char(shift_next[WORD_W-1]);
            end
          end
        end
`ifdef DUMP_CRLF_EN
        LN_SEND_CR: begin
          if (accept) begin
            tx_data   <= CHAR_LF;
            state_reg <= LN_SEND_NL;
          end
        end
`endif
        LN_SEND_NL: begin
          if (accept) begin
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            state_reg <= LN_IDLE;
          end
        end
        default: state_reg <= LN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/binary_dump_tx.sv
// binary_dump_tx: dumps the register file and then data memory as ASCII
// binary lines (one word per line, MSB first) over a valid/ready byte port.
// Ports:
//   clock, reset          clock, asynchronous active-low reset
//   start                 one-cycle dump request (dropped while busy / in DONE)
//   busy                  high from accepted start until the DONE cycle
//   done                  one-cycle pulse after the last terminator is accepted
//   rd_en, rd_sel,        read strobe, bank select (0 reg, 1 mem) and word
//   rd_addr[ADDR_W]       index toward the state source
//   rd_data[WORD_W]       read data, valid one cycle after rd_en
//   tx_data[8], tx_valid  ASCII byte stream toward the sink
//   tx_ready              sink ready
// Optional feature macro: DUMP_CRLF_EN terminates lines with CR LF.
module binary_dump_tx
  import dump_pkg::*;
#(
  parameter int WORD_W = 12,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  dump_state_t state_reg;
  logic        line_load;
  logic        line_done;

  // The source answers during WAIT, so the serializer captures rd_data then;
  // later changes to the source cannot affect the line in flight.
  assign line_load = (state_reg == ST_WAIT);

  dump_line_ser #(
    .WORD_W(WORD_W)
  ) u_line_ser (
    .clock    (clock),
    .reset    (reset),
    .load     (line_load),
    .word     (rd_data),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .line_done(line_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_sel    <= BANK_REG;
      rd_addr   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            rd_sel    <= BANK_REG;
            rd_addr   <= '0;
            rd_en     <= 1'b1;
            state_reg <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          rd_en     <= 1'b0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          state_reg <= ST_SEND;
        end
        ST_SEND: begin
          if (line_done) state_reg <= ST_NEXT;
        end
        ST_NEXT: begin
          if (rd_addr != ADDR_LAST) begin
            rd_addr   <= rd_addr + ADDR_W'(1);
            rd_en     <= 1'b1;
            state_reg <= ST_FETCH;
          end else if (rd_sel == BANK_REG) begin
            rd_sel    <= BANK_MEM;
            rd_addr   <= '0;
            rd_en     <= 1'b1;
            state_reg <= ST_FETCH;
          end else begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start is not looked at here, so a request in this cycle is dropped.
          done      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
